// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexed fully-connected layer controller: one signed MAC
// shared across N_OUT neurons, with Q-format rescale, ReLU and saturation.
module neuron_layer_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 40,
    localparam int NE   = N_OUT * (N_IN + 1),
    localparam int AW   = (NE > 1) ? $clog2(NE) : 1,
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*DW-1:0] in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_y,
    output logic [IW-1:0]      out_idx,
    output logic               out_last,
    output logic               busy
);

    localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        EMIT
    } state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]   mem [NE];
    logic signed [DW-1:0]   xr  [N_IN];
    logic [IW-1:0]          n;
    logic [XW-1:0]          i;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_sh;
    logic signed [ACCW-1:0] maxv;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          y_sat;
    logic [AW-1:0]          widx;
    logic [AW-1:0]          bidx_nx;
    logic                   last_i;
    logic                   last_n;
    logic                   capture;
    logic                   oshake;
    logic                   we;

    function automatic logic signed [ACCW-1:0] bias_acc(
        input logic signed [DW-1:0] b
    );
        logic signed [ACCW-1:0] t;
        t = {{(ACCW-DW){b[DW-1]}}, b};
        return t <<< FRAC;
    endfunction

    assign last_i  = (i == XW'(N_IN - 1));
    assign last_n  = (n == IW'(N_OUT - 1));
    assign capture = (state == IDLE) && in_valid;
    assign oshake  = (state == EMIT) && out_ready;
    assign we      = (state == IDLE) && cfg_we && (int'(cfg_addr) < NE);
    assign widx    = AW'(int'(n) * (N_IN + 1) + int'(i));
    assign bidx_nx = AW'((int'(n) + 1) * (N_IN + 1) + N_IN);
    assign prod    = xr[i] * mem[widx];
    assign acc_sh  = acc >>> FRAC;
    assign maxv    = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};

    always_comb begin
        y_sat = '0;
        if (acc_sh[ACCW-1])
            y_sat = '0;
        else if (acc_sh > maxv)
            y_sat = maxv[DW-1:0];
        else
            y_sat = acc_sh[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_y     = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (capture)
                    state_nx = MAC;
            end
            MAC: begin
                if (last_i)
                    state_nx = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_y     = y_sat;
                out_idx   = n;
                out_last  = last_n;
                if (out_ready)
                    state_nx = last_n ? IDLE : MAC;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bias is read at the capture edge; weights only from the next cycle,
    // so a weight written alongside the capture is already visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            n   <= '0;
            i   <= '0;
            for (int k = 0; k < N_IN; k++)
                xr[k] <= '0;
            for (int k = 0; k < NE; k++)
                mem[k] <= '0;
        end else begin
            if (we)
                mem[cfg_addr] <= cfg_data;
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < N_IN; k++)
                            xr[k] <= in_x[k*DW +: DW];
                        n   <= '0;
                        i   <= '0;
                        acc <= bias_acc(mem[AW'(N_IN)]);
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
                    i   <= i + XW'(1);
                end
                EMIT: begin
                    if (oshake && !last_n) begin
                        n   <= n + IW'(1);
                        i   <= '0;
                        acc <= bias_acc(mem[bidx_nx]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Randomised bench for neuron_layer_sequencer with a behavioural
// arithmetic model of the layer (weights, bias, rescale, ReLU, clamp).
module tb_neuron_layer_sequencer;

    localparam int N_IN  = 2;
    localparam int N_OUT = 4;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACCW  = 40;
    localparam int NE    = N_OUT * (N_IN + 1);
    localparam int AW    = 4;
    localparam int IW    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [DW-1:0]      cfg_data;
    logic               in_valid;
    logic               in_ready;
    logic [N_IN*DW-1:0] in_x;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_y;
    logic [IW-1:0]      out_idx;
    logic               out_last;
    logic               busy;

    int vectors;
    int miscompares;
    int wm [NE];
    int xv [N_IN];
    int got_y [N_OUT];

    neuron_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACCW(ACCW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx16(input int v);
        logic signed [15:0] d;
        d = v[15:0];
        return int'(d);
    endfunction

    function automatic int model_y(input int n);
        longint acc;
        int base;
        base = n * (N_IN + 1);
        acc = longint'(wm[base + N_IN]) * (longint'(1) << FRAC);
        for (int k = 0; k < N_IN; k++)
            acc += longint'(xv[k]) * longint'(wm[base + k]);
        acc = acc >>> FRAC;
        if (acc < 0) return 0;
        if (acc > 32767) return 32767;
        return int'(acc);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_y"}, int'(out_y), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = addr[AW-1:0];
        cfg_data = data[DW-1:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (addr < NE)
            wm[addr] = sx16(data);
    endtask

    task automatic load_neuron(input int n, input int w0, input int w1,
                               input int b);
        cfg_write(n * 3 + 0, w0);
        cfg_write(n * 3 + 1, w1);
        cfg_write(n * 3 + 2, b);
    endtask

    task automatic run_vector(input bit bp, input bit junk, input bit cap_wr,
                              input int cap_data, input int abort_at);
        int t;
        int lat;
        int ey;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        for (int k = 0; k < N_IN; k++)
            in_x[k*DW +: DW] = xv[k][DW-1:0];
        in_valid = 1'b1;
        if (cap_wr) begin
            cfg_we   = 1'b1;
            cfg_addr = '0;
            cfg_data = cap_data[DW-1:0];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (cap_wr)
            wm[0] = sx16(cap_data);
        in_x = {$urandom, $urandom};
        for (int n = 0; n < N_OUT; n++) begin
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                for (int k = 0; k < NE; k++)
                    wm[k] = 0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            ey  = model_y(n);
            lat = 0;
            while (!out_valid && lat < 40) begin
                if (junk) begin
                    in_valid = 1'($urandom);
                    cfg_we   = 1'($urandom);
                    cfg_addr = AW'($urandom);
                    cfg_data = DW'($urandom);
                    check("in_ready_busy", int'(in_ready), 0);
                end
                @(posedge clk); #1;
                lat++;
            end
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            check("latency", lat, N_IN);
            check("out_valid", int'(out_valid), 1);
            check("out_y", int'($signed(out_y)), ey);
            check("out_idx", int'(out_idx), n);
            check("out_last", int'(out_last), (n == N_OUT - 1) ? 1 : 0);
            got_y[n] = int'($signed(out_y));
            if (bp) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_valid", int'(out_valid), 1);
                    check("bp_y", int'($signed(out_y)), ey);
                    check("bp_idx", int'(out_idx), n);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("done_in_ready", int'(in_ready), 1);
        check("done_busy", int'(busy), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < NE; k++)
            wm[k] = 0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        load_neuron(0, 256, 256, 0);
        xv[0] = 1000; xv[1] = 2000;
        run_vector(0, 0, 0, 0, -1);
        check("basic_sum", got_y[0], 3000);

        load_neuron(0, 256, 0, 0);
        load_neuron(1, 0, 256, 0);
        load_neuron(2, 128, 128, 0);
        load_neuron(3, -256, 0, 0);
        run_vector(0, 0, 0, 0, -1);
        check("layer_n0", got_y[0], 1000);
        check("layer_n1", got_y[1], 2000);
        check("layer_n2", got_y[2], 1500);
        check("layer_n3", got_y[3], 0);

        load_neuron(0, 512, 512, 0);
        xv[0] = 20000; xv[1] = 20000;
        run_vector(0, 0, 0, 0, -1);
        check("saturate", got_y[0], 32767);

        load_neuron(0, 0, 0, 100);
        run_vector(0, 0, 0, 0, -1);
        check("bias_only", got_y[0], 100);

        load_neuron(0, 256, 0, -50);
        xv[0] = 30; xv[1] = 777;
        run_vector(0, 0, 0, 0, -1);
        check("relu", got_y[0], 0);

        load_neuron(0, 256, 0, 0);
        xv[0] = 1234; xv[1] = -555;
        run_vector(1, 1, 0, 0, -1);
        check("junk_n0", got_y[0], 1234);
        run_vector(0, 0, 0, 0, -1);
        check("after_junk_n0", got_y[0], 1234);

        run_vector(0, 0, 1, 512, -1);
        check("cap_write_n0", got_y[0], 2468);

        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < NE; k++) begin
                if ($urandom_range(0, 1) == 1)
                    cfg_write(k, int'($urandom_range(0, 65535)) - 32768);
                else
                    cfg_write(k, int'($urandom_range(0, 1024)) - 512);
            end
            cfg_write(int'($urandom_range(NE, 15)), int'($urandom_range(0, 65535)));
            for (int k = 0; k < N_IN; k++)
                xv[k] = int'($urandom_range(0, 65535)) - 32768;
            run_vector(1'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 65535)), -1);
        end

        load_neuron(2, 256, 256, 10);
        xv[0] = 300; xv[1] = 400;
        run_vector(0, 0, 0, 0, 2);
        xv[0] = 5000; xv[1] = -7000;
        run_vector(0, 0, 0, 0, -1);
        for (int n = 0; n < N_OUT; n++)
            check("cleared_w", got_y[n], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Controller that time-multiplexes one signed 16x16 multiply-accumulate datapath across a small fully-connected layer. Each layer has N_OUT neurons and N_IN inputs. The block holds the layer's weights and biases in an internal register file, loaded through a config port. It accepts an input vector through a valid/ready handshake, sequences the MAC neuron by neuron, and applies Q-format rescale, ReLU and saturation. It streams one 16-bit result per neuron through a valid/ready output. It sits between the input-sample source and downstream layer logic, replacing N_OUT parallel neuron instances.

Parameters:
N_IN, 2, inputs per neuron (>=1)
N_OUT, 4, neurons in the layer (>=1)
DW, 16, data/weight width, signed two's complement
FRAC, 8, fractional bits of weights (Q(DW-FRAC).FRAC); 256 = 1.0
ACCW, 40, accumulator width; must be >= 2*DW + clog2(N_IN+1) + 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  weight/bias write strobe
cfg_addr  in  clog2(N_OUT*(N_IN+1))  address = n*(N_IN+1)+i; i<N_IN is weight w[n][i], i==N_IN is bias b[n]
cfg_data  in  DW  signed weight/bias value
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_x  in  N_IN*DW  input vector; x[i] = in_x[i*DW +: DW], signed
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  DW  signed neuron result
out_idx  out  clog2(N_OUT) (min 1)  neuron index of out_y
out_last  out  1  high with the result of neuron N_OUT-1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_y=0, out_idx=0, out_last=0, busy=0.
  - Accumulator, neuron counter, input counter and captured inputs are cleared to 0.
  - All weights and biases are cleared to 0.
- State IDLE:
  - in_ready=1.
  - cfg_we with an in-range cfg_addr writes the entry at the clock edge. Out-of-range addresses are ignored.
  - in_valid&&in_ready captures in_x into internal registers, sets n=0, i=0, acc = sign_ext(b[0]) << FRAC, and moves to MAC.
  - When cfg_we and capture occur in the same cycle, the write still lands. MAC reads weights only from the next cycle, so the new value is used.
- State MAC:
  - in_ready=0. cfg_we is ignored (no write).
  - Each cycle: acc <= acc + x[i]*w[n][i] (full-precision signed product, sign-extended to ACCW), then i <= i+1.
  - On the edge where i==N_IN-1 the state moves to EMIT.
  - A neuron takes exactly N_IN MAC cycles.
- State EMIT:
  - out_valid=1, out_idx=n, out_last=(n==N_OUT-1).
  - out_y = clamp(relu(acc >>> FRAC)): arithmetic shift; negative values give 0; values > 2^(DW-1)-1 give 2^(DW-1)-1.
  - out_y, out_idx and out_last are held stable while out_ready=0; there is no timeout.
  - On out_valid&&out_ready:
    - If n==N_OUT-1: go to IDLE; in_ready rises the next cycle.
    - Otherwise: n <= n+1, i <= 0, acc <= sign_ext(b[n+1]) << FRAC, go to MAC.
- Latency:
  - out_valid for neuron 0 rises N_IN cycles after the capture edge.
  - Each later neuron's out_valid rises N_IN cycles after the previous output handshake.
  - Minimum per vector with no back-pressure: N_OUT*(N_IN+1) cycles + 1 IDLE cycle.
- Results are computed from the inputs captured at acceptance; in_x may change freely after capture.
- The accumulator never wraps, given the ACCW rule.
- busy = (state != IDLE).

Test Plan:
- Basic Q8.8 sum: w[0]={256,256}, b[0]=0; in_x={x0=1000, x1=2000}; out_ready=1 -> out_y=3000, out_idx=0, out_valid rises 2 cycles after capture.
- Full layer order: neurons 0..3 with w={256,0}, {0,256}, {128,128}, {-256,0}, b=0; x={1000,2000} -> results 1000, 2000, 1500, 0. out_idx runs 0..3, out_last only on the 4th result, in_ready returns 1 cycle after the last handshake.
- Saturation and bias: w[0]={512,512}, x={20000,20000} -> 32767. Second case: w[0]={0,0}, b[0]=100 -> out_y=100. Third case: w[0]={256,0}, b[0]=-50, x0=30 -> 0 (ReLU).
- Back-pressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid, out_y and out_idx stay stable. Change in_x during processing -> no effect on results. Raising in_valid while busy -> not accepted.
- Config protection: cfg_we writing w[0][0]=0 during MAC -> ignored, current and next vectors still use the old weight. Same write in IDLE in the same cycle as capture -> new weight is used.
- Reset mid-operation: assert rst while in MAC for neuron 2 -> outputs immediately go to reset values. After release, a vector with no reload gives out_y=0 for all neurons, since weights were cleared.
